fb_fill: RTL



---
 rtl/fb_pkg.sv | 25 ++
 rtl/fb_fill.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/fb_pkg.sv
// rtl/fb_pkg.sv - shared state encoding, frame-buffer defaults and a constant shift-add helper for fb_fill.
package fb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } fb_state_t;

    localparam int FB_WIDTH_DEF     = 400;
    localparam int FB_HEIGHT_DEF    = 300;
    localparam int CHANNEL_BITS_DEF = 2;

    // Shift-and-add product; with a constant k this folds to a few adders.
    function automatic logic [31:0] fb_mul_const(input logic [31:0] a, input logic [31:0] k);
        logic [31:0] acc;
        acc = 32'd0;
        for (int i = 0; i < 32; i++) begin
            if (k[i]) begin
                acc = acc + (a << i);
            end
        end
        return acc;
    endfunction

endpackage

// File: rtl/fb_fill.sv
// rtl/fb_fill.sv - rectangle fill engine writing one clipped pixel per cycle into a byte-per-pixel frame buffer.
module fb_fill
    import fb_pkg::*;
#(
    parameter int FB_WIDTH         = FB_WIDTH_DEF,
    parameter int FB_HEIGHT        = FB_HEIGHT_DEF,
    parameter int COORD_BITS       = 9,
    parameter int BUFFER_ADDR_BITS = 17,
    parameter int CHANNEL_BITS     = CHANNEL_BITS_DEF
) (
    input  logic                        clk,
    input  logic                        resetn,
    input  logic                        cmd_valid,
    output logic                        cmd_ready,
    input  logic [COORD_BITS-1:0]       cmd_x,
    input  logic [COORD_BITS-1:0]       cmd_y,
    input  logic [COORD_BITS-1:0]       cmd_w,
    input  logic [COORD_BITS-1:0]       cmd_h,
    input  logic [3*CHANNEL_BITS-1:0]   cmd_color,
    output logic                        busy,
    output logic                        done,
    output logic [31:0]                 buffer_addr,
    output logic [31:0]                 buffer_din,
    output logic                        buffer_en,
    output logic                        buffer_rst,
    output logic [3:0]                  buffer_we
);

    localparam int CW         = COORD_BITS + 1;
    localparam int AB         = BUFFER_ADDR_BITS;
    localparam int COLOR_BITS = 3 * CHANNEL_BITS;

    localparam logic [CW-1:0] W_LIM  = CW'(FB_WIDTH);
    localparam logic [CW-1:0] H_LIM  = CW'(FB_HEIGHT);
    localparam logic [AB-1:0] W_STEP = AB'(FB_WIDTH);

    fb_state_t state;
    fb_state_t state_next;

    logic                  accept;
    logic                  empty_cmd;
    logic                  row_last;
    logic                  last_pixel;
    logic [CW-1:0]         x_sum;
    logic [CW-1:0]         y_sum;
    logic [CW-1:0]         x_end_c;
    logic [CW-1:0]         y_end_c;
    logic [AB-1:0]         row_base_c;

    logic [CW-1:0]         x_q;
    logic [CW-1:0]         y_q;
    logic [CW-1:0]         x_start_q;
    logic [CW-1:0]         x_end_q;
    logic [CW-1:0]         y_end_q;
    logic [AB-1:0]         row_base_q;
    logic [AB-1:0]         addr_q;
    logic [COLOR_BITS-1:0] color_q;
    logic                  done_q;
    logic [7:0]            color_byte;

    assign accept = cmd_valid && (state == IDLE);

    // Sums carry one extra bit so x+w and y+h never wrap before clipping.
    assign x_sum   = {1'b0, cmd_x} + {1'b0, cmd_w};
    assign y_sum   = {1'b0, cmd_y} + {1'b0, cmd_h};
    assign x_end_c = (x_sum > W_LIM) ? W_LIM : x_sum;
    assign y_end_c = (y_sum > H_LIM) ? H_LIM : y_sum;

    assign empty_cmd = (cmd_w == '0) || (cmd_h == '0) ||
                       ({1'b0, cmd_x} >= W_LIM) || ({1'b0, cmd_y} >= H_LIM);

    assign row_base_c = AB'(fb_mul_const(32'(cmd_y), 32'(FB_WIDTH)));

    assign row_last   = ((x_q + CW'(1)) == x_end_q);
    assign last_pixel = row_last && ((y_q + CW'(1)) == y_end_q);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        cmd_ready  = 1'b0;
        busy       = 1'b0;
        buffer_we  = 4'b0000;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (accept && !empty_cmd) begin
                    state_next = FILL;
                end
            end
            FILL: begin
                busy      = 1'b1;
                buffer_we = 4'b0001 << addr_q[1:0];
                if (last_pixel) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            x_q        <= '0;
            y_q        <= '0;
            x_start_q  <= '0;
            x_end_q    <= '0;
            y_end_q    <= '0;
            row_base_q <= '0;
            addr_q     <= '0;
            color_q    <= '0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (accept) begin
                x_q        <= {1'b0, cmd_x};
                y_q        <= {1'b0, cmd_y};
                x_start_q  <= {1'b0, cmd_x};
                x_end_q    <= x_end_c;
                y_end_q    <= y_end_c;
                row_base_q <= row_base_c;
                addr_q     <= row_base_c + AB'(cmd_x);
                color_q    <= cmd_color;
                done_q     <= empty_cmd;
            end else if (state == FILL) begin
                if (last_pixel) begin
                    done_q <= 1'b1;
                end else if (row_last) begin
                    // Wrap to the clipped left edge of the next row.
                    x_q        <= x_start_q;
                    y_q        <= y_q + CW'(1);
                    row_base_q <= row_base_q + W_STEP;
                    addr_q     <= row_base_q + W_STEP + AB'(x_start_q);
                end else begin
                    x_q    <= x_q + CW'(1);
                    addr_q <= addr_q + AB'(1);
                end
            end
        end
    end

    assign color_byte  = 8'(color_q);
    assign done        = done_q;
    assign buffer_addr = 32'(addr_q);
    assign buffer_din  = {4{color_byte}};
    assign buffer_en   = 1'b1;
    assign buffer_rst  = 1'b0;

endmodule
